axi_spi_lite_regs: RTL and testbench
====================================

Name: axi_spi_lite_regs

Overview:
AXI4-Lite responder (slave) holding the four 32-bit control/data registers of the SPI peripheral. It accepts single-beat writes and reads from the bus master, answers every access with OKAY, and exports the register contents plus one-cycle access strobes to the SPI engine. It occupies the S00_AXI port of the IP, at byte offsets 0x0, 0x4, 0x8 and 0xC.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, address bus width; bits [3:2] select the register, all other bits are ignored.

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address accepted
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data accepted
S_AXI_BRESP  out  2  write response, always 2'b00
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address accepted
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response, always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg0_o..reg3_o  out  32 each  current register contents
reg_wr_pulse  out  4  one-hot, one-cycle strobe marking the register just written
reg_rd_pulse  out  4  one-hot, one-cycle strobe marking the register just read

Behaviour:
- Reset (ARESET=1 at a rising edge) forces all outputs to 0: the four registers, every READY/VALID, BRESP, RRESP, RDATA, and both pulse vectors. Reset aborts any transaction in flight. No B or R response is issued for an aborted transaction.
- Write FSM, three states:
  - W_IDLE: when AWVALID=1 and WVALID=1 in cycle N, go to W_ACK.
  - W_ACK (cycle N+1): AWREADY=WREADY=1 for exactly this one cycle. Address and data are sampled in this cycle. The selected register is updated at the closing edge, per byte lane where WSTRB[i]=1. reg_wr_pulse is asserted in cycle N+2. Go to W_RESP.
  - W_RESP: BVALID=1, BRESP=00. BVALID holds until the cycle with BREADY=1, then return to W_IDLE. BVALID deasserts the cycle after that handshake.
  - AW without W, or W without AW: the block waits in W_IDLE and asserts no READY.
  - A new write cannot be accepted before the cycle after the B handshake. Max throughput is one write per 3 cycles.
- Read FSM, three states, independent of the write FSM:
  - R_IDLE: when ARVALID=1 in cycle N, go to R_ACK.
  - R_ACK (cycle N+1): ARREADY=1 for exactly this one cycle. ARADDR is sampled. RDATA is loaded from the selected register at the closing edge. Go to R_DATA.
  - R_DATA: RVALID=1 with RRESP=00. RDATA is stable while RVALID=1 and RREADY=0. reg_rd_pulse is asserted in the first R_DATA cycle only. Return to R_IDLE after the R handshake.
- Read and write hitting the same register on the same edge (W_ACK and R_ACK coincide): the read returns the pre-write value.
- WSTRB=0000: registers are unchanged, but the write still completes with an OKAY response and reg_wr_pulse still fires.
- Every address decodes to a register; no error response exists.

Test Plan:
- Reset released, then write 0x0101FFFF/0xabcd0001/0xdead0011/0xbeef0011 to 0x0/0x4/0x8/0xC with full strobes, reading each back after its write -> each read returns the written value; all BRESP and RRESP are 00; reg_wr_pulse is 0001/0010/0100/1000 in turn.
- Reg2=0xdead0011, then write 0xabcd0001 with WSTRB=0011 -> reads 0xdead0001; reg2_o matches.
- AWVALID raised 3 cycles before WVALID -> AWREADY stays low until WVALID has been seen for one cycle; AWREADY and WREADY then assert together for a single cycle.
- BREADY held low 5 cycles after a write while a second AW/W pair waits -> BVALID stays high; no READY for the second write until the cycle after the B handshake.
- Reg1=0x11111111, then write 0x22222222 to 0x4 and read 0x4 issued in the same cycle -> read returns 0x11111111; a subsequent read returns 0x22222222.
- ARESET pulsed while in W_RESP and R_DATA -> next cycle: BVALID=RVALID=0, all registers 0, and neither a B nor an R response appears afterwards.

Source files
------------

// File: rtl/axi_spi_lite_regs.sv
// AXI4-Lite register block for the SPI peripheral: four 32-bit registers with
// independent write and read handshake FSMs and one-cycle access strobes.
//
// state  | meaning
// -------+----------------------------------------------------------------
// W_IDLE | waiting for AWVALID and WVALID together
// W_ACK  | AWREADY/WREADY high; selected register updated at closing edge
// W_RESP | BVALID high until BREADY
// R_IDLE | waiting for ARVALID
// R_ACK  | ARREADY high; RDATA loaded at closing edge
// R_DATA | RVALID high until RREADY

module axi_spi_lite_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      reg_wr_pulse,
  output logic [3:0]                      reg_rd_pulse
);

  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [3:0]                    wr_pulse_q;
  logic [3:0]                    rd_pulse_q;
  logic [1:0]                    wr_sel;
  logic [1:0]                    rd_sel;
  logic                          aw_ready;
  logic                          w_ready;
  logic                          b_valid;
  logic                          wr_en;
  logic                          ar_ready;
  logic                          r_valid;
  logic                          rd_en;

  // Protection bits and the byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign wr_sel = S_AXI_AWADDR[3:2];
  assign rd_sel = S_AXI_ARADDR[3:2];

  // Write FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    wr_en       = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          w_state_nxt = W_ACK;
        end
      end
      W_ACK: begin
        aw_ready    = 1'b1;
        w_ready     = 1'b1;
        wr_en       = 1'b1;
        w_state_nxt = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (S_AXI_BREADY) begin
          w_state_nxt = W_IDLE;
        end
      end
      default: begin
        w_state_nxt = W_IDLE;
      end
    endcase
  end

  // Read FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    ar_ready    = 1'b0;
    r_valid     = 1'b0;
    rd_en       = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          r_state_nxt = R_ACK;
        end
      end
      R_ACK: begin
        ar_ready    = 1'b1;
        rd_en       = 1'b1;
        r_state_nxt = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (S_AXI_RREADY) begin
          r_state_nxt = R_IDLE;
        end
      end
      default: begin
        r_state_nxt = R_IDLE;
      end
    endcase
  end

  // Register file with byte-lane enables
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
      wr_pulse_q <= 4'b0000;
    end else begin
      wr_pulse_q <= 4'b0000;
      if (wr_en) begin
        for (int b = 0; b < NB; b++) begin
          if (S_AXI_WSTRB[b]) begin
            regs_q[wr_sel][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
          end
        end
        wr_pulse_q <= 4'b0001 << wr_sel;
      end
    end
  end

  // Read data is taken from the register array before any same-edge write lands.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdata_q    <= '0;
      rd_pulse_q <= 4'b0000;
    end else begin
      rd_pulse_q <= 4'b0000;
      if (rd_en) begin
        rdata_q    <= regs_q[rd_sel];
        rd_pulse_q <= 4'b0001 << rd_sel;
      end
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;

  assign reg0_o       = regs_q[0];
  assign reg1_o       = regs_q[1];
  assign reg2_o       = regs_q[2];
  assign reg3_o       = regs_q[3];
  assign reg_wr_pulse = wr_pulse_q;
  assign reg_rd_pulse = rd_pulse_q;

endmodule

// File: tb/tb_axi_spi_lite_regs.sv
// Bench for axi_spi_lite_regs: directed handshake scenarios plus randomized
// accesses checked against a word-level register model.

module tb_axi_spi_lite_regs;

  logic        tb_ACLK = 1'b0;
  logic        areset;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
  logic [3:0]  reg_wr_pulse, reg_rd_pulse;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_regs [4];

  always #5 tb_ACLK = ~tb_ACLK;

  axi_spi_lite_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(tb_ACLK), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready), .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .reg3_o(reg3_o), .reg_wr_pulse(reg_wr_pulse), .reg_rd_pulse(reg_rd_pulse)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_out(input int i);
    case (i)
      0: return reg0_o;
      1: return reg1_o;
      2: return reg2_o;
      default: return reg3_o;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] mask = 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) mask = mask | (32'hff << (8*i));
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [3:0] one_hot(input logic [3:0] addr);
    logic [3:0] v = 4'b0001;
    return v << addr[3:2];
  endfunction

  task automatic do_write(input logic [3:0] addr, input logic [31:0] d,
                          input logic [3:0] s, input int aw_lead, input int bdelay);
    int n;
    int idx = int'(addr[3:2]);
    awaddr = addr; wdata = d; wstrb = s; awvalid = 1'b1;
    for (int k = 0; k < aw_lead; k++) begin
      @(negedge tb_ACLK);
      check_val("aw_only_no_ready", {30'd0, awready, wready}, 32'd0);
    end
    wvalid = 1'b1;
    n = 0;
    @(negedge tb_ACLK);
    while (!awready && n < 20) begin @(negedge tb_ACLK); n++; end
    check_val("aw_latency", n, 0);
    check_val("wready_with_awready", {31'd0, wready}, 32'd1);
    @(negedge tb_ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    model_regs[idx] = merge(model_regs[idx], d, s);
    check_val("awready_one_cycle", {30'd0, awready, wready}, 32'd0);
    check_val("bvalid", {31'd0, bvalid}, 32'd1);
    check_val("bresp", {30'd0, bresp}, 32'd0);
    check_val("wr_pulse", {28'd0, reg_wr_pulse}, {28'd0, one_hot(addr)});
    check_val("reg_out", reg_out(idx), model_regs[idx]);
    for (int k = 0; k < bdelay; k++) begin
      @(negedge tb_ACLK);
      check_val("bvalid_hold", {31'd0, bvalid}, 32'd1);
      check_val("wr_pulse_once", {28'd0, reg_wr_pulse}, 32'd0);
    end
    bready = 1'b1;
    @(negedge tb_ACLK);
    bready = 1'b0;
    check_val("bvalid_drop", {31'd0, bvalid}, 32'd0);
    check_val("wr_pulse_clear", {28'd0, reg_wr_pulse}, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input int rdelay);
    int n;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    @(negedge tb_ACLK);
    while (!arready && n < 20) begin @(negedge tb_ACLK); n++; end
    check_val("ar_latency", n, 0);
    @(negedge tb_ACLK);
    arvalid = 1'b0;
    check_val("arready_one_cycle", {31'd0, arready}, 32'd0);
    check_val("rvalid", {31'd0, rvalid}, 32'd1);
    check_val("rresp", {30'd0, rresp}, 32'd0);
    check_val("rdata", rdata, exp);
    check_val("rd_pulse", {28'd0, reg_rd_pulse}, {28'd0, one_hot(addr)});
    for (int k = 0; k < rdelay; k++) begin
      @(negedge tb_ACLK);
      check_val("rdata_stable", rdata, exp);
      check_val("rvalid_hold", {31'd0, rvalid}, 32'd1);
      check_val("rd_pulse_once", {28'd0, reg_rd_pulse}, 32'd0);
    end
    rready = 1'b1;
    @(negedge tb_ACLK);
    rready = 1'b0;
    check_val("rvalid_drop", {31'd0, rvalid}, 32'd0);
    check_val("rd_pulse_clear", {28'd0, reg_rd_pulse}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valids"}, {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    check_val({tag, "_resps"}, {28'd0, bresp, rresp}, 32'd0);
    check_val({tag, "_rdata"}, rdata, 32'd0);
    check_val({tag, "_pulses"}, {24'd0, reg_wr_pulse, reg_rd_pulse}, 32'd0);
    for (int i = 0; i < 4; i++) check_val({tag, "_reg"}, reg_out(i), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] tv_data [4];
    logic [31:0] pre;
    logic [3:0]  a, ra;
    logic [31:0] d;
    logic [3:0]  s;

    tv_data[0] = 32'h0101FFFF; tv_data[1] = 32'habcd0001;
    tv_data[2] = 32'hdead0011; tv_data[3] = 32'hbeef0011;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;

    areset = 1'b1; awaddr = 4'h0; awprot = 3'b000; awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
    araddr = 4'h0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    check_all_zero("reset");
    areset = 1'b0;
    @(negedge tb_ACLK);

    // Full-strobe writes with read-back
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      do_write(a, tv_data[i], 4'hf, 0, 0);
      do_read(a, model_regs[i], 0);
    end

    // Partial strobe on reg2
    do_write(4'h8, 32'habcd0001, 4'b0011, 0, 1);
    check_val("partial_reg2", reg2_o, 32'hdead0001);
    do_read(4'h8, 32'hdead0001, 2);

    // Zero strobe: no change, still responds and pulses
    do_write(4'h4, 32'h55555555, 4'b0000, 0, 0);
    do_read(4'h4, 32'habcd0001, 0);

    // AW leads W by three cycles
    do_write(4'hC, 32'h12345678, 4'hf, 3, 0);

    // BREADY held low while a second write waits
    do_write(4'h0, 32'hcafef00d, 4'hf, 0, 0);
    awaddr = 4'h4; wdata = 32'h0badbeef; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge tb_ACLK);
    check_val("bp_first_ack", {30'd0, awready, wready}, 32'd3);
    model_regs[1] = 32'h0badbeef;
    for (int k = 0; k < 5; k++) begin
      @(negedge tb_ACLK);
      awaddr = 4'h8; wdata = 32'h600d600d;
      check_val("bp_bvalid_hold", {31'd0, bvalid}, 32'd1);
      check_val("bp_no_ready", {30'd0, awready, wready}, 32'd0);
    end
    bready = 1'b1;
    @(negedge tb_ACLK);
    bready = 1'b0;
    check_val("bp_bvalid_drop", {31'd0, bvalid}, 32'd0);
    check_val("bp_idle_no_ready", {30'd0, awready, wready}, 32'd0);
    @(negedge tb_ACLK);
    check_val("bp_second_ack", {30'd0, awready, wready}, 32'd3);
    @(negedge tb_ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    model_regs[2] = 32'h600d600d;
    check_val("bp_second_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    @(negedge tb_ACLK);
    bready = 1'b0;
    check_val("bp_reg1", reg1_o, model_regs[1]);
    check_val("bp_reg2", reg2_o, model_regs[2]);

    // Same-edge read and write to reg1
    do_write(4'h4, 32'h11111111, 4'hf, 0, 0);
    fork
      do_write(4'h4, 32'h22222222, 4'hf, 0, 1);
      do_read(4'h4, 32'h11111111, 1);
    join
    do_read(4'h4, 32'h22222222, 0);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      a  = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        pre = model_regs[ra[3:2]];
        fork
          do_write(a, d, s, 0, $urandom_range(0, 2));
          do_read(ra, pre, $urandom_range(0, 2));
        join
      end else begin
        do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2));
        do_read(ra, model_regs[ra[3:2]], $urandom_range(0, 2));
      end
    end
    for (int i = 0; i < 4; i++) check_val("rand_reg_out", reg_out(i), model_regs[i]);

    // Reset with a write in W_RESP and a read in R_DATA
    awaddr = 4'h0; wdata = 32'hffffffff; wstrb = 4'hf; araddr = 4'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge tb_ACLK);
    @(negedge tb_ACLK);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_val("pre_reset_valids", {30'd0, bvalid, rvalid}, 32'd3);
    areset = 1'b1;
    @(negedge tb_ACLK);
    areset = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    check_all_zero("abort");
    bready = 1'b1; rready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge tb_ACLK);
      check_val("no_resp_after_abort", {30'd0, bvalid, rvalid}, 32'd0);
    end
    bready = 1'b0; rready = 1'b0;
    do_read(4'h0, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
